// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Brief    : Bundle of the two requester ports and the data-memory port of
//             dmem_arbiter. The slave modport is the arbiter's view; the
//             master modport is the view of the requesters plus the memory.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Requester 0 (core load/store unit)
    logic                  m0_req;
    logic                  m0_we;
    logic [2:0]            m0_funct3;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_err;

    // Requester 1 (debug / DMA loader)
    logic                  m1_req;
    logic                  m1_we;
    logic [2:0]            m1_funct3;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_err;

    // Single-port data memory
    logic                  mem_wr_en;
    logic [2:0]            mem_funct3;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  m0_req, m0_we, m0_funct3, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_funct3, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_wr_en, mem_funct3, mem_addr, mem_wdata,
        input  mem_rd_data
    );

    modport master (
        output m0_req, m0_we, m0_funct3, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_funct3, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_wr_en, mem_funct3, mem_addr, mem_wdata,
        output mem_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Round-robin arbiter and sequencer sharing one single-port data
//             memory between two requesters. Each accepted command spends one
//             cycle on the memory port (ISSUE) and is answered one cycle later
//             (RESP). Illegal or misaligned accesses are granted and answered
//             with an error but never reach the memory write enable.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and command registers
    // ------------------------------------------------------------------------
    state_t                state_q;
    logic                  ptr_q;        // last winner (0 = m0, 1 = m1)
    logic                  win_q;        // owner of the command in flight
    logic                  cmd_we_q;
    logic                  cmd_legal_q;

    // Registered outputs
    logic                  m0_gnt_q;
    logic                  m0_rvalid_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q;
    logic                  m0_err_q;
    logic                  m1_gnt_q;
    logic                  m1_rvalid_q;
    logic [DATA_WIDTH-1:0] m1_rdata_q;
    logic                  m1_err_q;
    logic                  mem_wr_en_q;
    logic [2:0]            mem_funct3_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    // ------------------------------------------------------------------------
    // Next-command selection
    // ------------------------------------------------------------------------
    logic                  any_req_d;
    logic                  win_d;
    logic                  we_d;
    logic [2:0]            funct3_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  legal_d;
    logic [DATA_WIDTH-1:0] rsp_data_d;

    // Loads accept all five RISC-V load sizes, stores only byte/half/word;
    // halfwords must be 2-byte aligned and words 4-byte aligned.
    function automatic logic f_legal(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lsb);
        logic ok;
        ok = 1'b0;
        case (funct3)
            3'b000:  ok = 1'b1;                         // lb / sb
            3'b001:  ok = ~addr_lsb[0];                 // lh / sh
            3'b010:  ok = (addr_lsb == 2'b00);          // lw / sw
            3'b100:  ok = ~we;                          // lbu
            3'b101:  ok = ~we & ~addr_lsb[0];           // lhu
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the winner: a lone requester always wins, a conflict goes to the
    // requester that did not win last time. Then mux its command fields.
    always_comb begin
        any_req_d = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            win_d = ~ptr_q;
        end else begin
            win_d = bus.m1_req;
        end

        if (win_d) begin
            we_d     = bus.m1_we;
            funct3_d = bus.m1_funct3;
            addr_d   = bus.m1_addr;
            wdata_d  = bus.m1_wdata;
        end else begin
            we_d     = bus.m0_we;
            funct3_d = bus.m0_funct3;
            addr_d   = bus.m0_addr;
            wdata_d  = bus.m0_wdata;
        end

        legal_d = f_legal(we_d, funct3_d, addr_d[1:0]);
    end

    // Response payload: only a legal load returns memory data, everything
    // else (stores, rejected accesses) answers with zero.
    always_comb begin
        rsp_data_d = '0;
        if (cmd_legal_q && !cmd_we_q) begin
            rsp_data_d = bus.mem_rd_data;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------------
    // IDLE/RESP arbitrate and load the command, ISSUE drives the memory for
    // one cycle and captures the read data, RESP presents the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b1;
            win_q        <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_legal_q  <= 1'b0;
            m0_gnt_q     <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m0_err_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m1_rdata_q   <= '0;
            m1_err_q     <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_funct3_q <= 3'b000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            // Pulse outputs default low; they are raised only for the one
            // cycle of the state that owns them.
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            mem_wr_en_q <= 1'b0;

            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (any_req_d) begin
                        state_q      <= ST_ISSUE;
                        ptr_q        <= win_d;
                        win_q        <= win_d;
                        cmd_we_q     <= we_d;
                        cmd_legal_q  <= legal_d;
                        // The memory-side registers double as the command
                        // registers; they only change when a command loads.
                        mem_funct3_q <= funct3_d;
                        mem_addr_q   <= addr_d;
                        mem_wdata_q  <= wdata_d;
                        mem_wr_en_q  <= we_d & legal_d;
                        m0_gnt_q     <= ~win_d;
                        m1_gnt_q     <= win_d;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    state_q <= ST_RESP;
                    if (win_q) begin
                        m1_rvalid_q <= 1'b1;
                        m1_rdata_q  <= rsp_data_d;
                        m1_err_q    <= ~cmd_legal_q;
                    end else begin
                        m0_rvalid_q <= 1'b1;
                        m0_rdata_q  <= rsp_data_d;
                        m0_err_q    <= ~cmd_legal_q;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.m0_gnt     = m0_gnt_q;
    assign bus.m0_rvalid  = m0_rvalid_q;
    assign bus.m0_rdata   = m0_rdata_q;
    assign bus.m0_err     = m0_err_q;
    assign bus.m1_gnt     = m1_gnt_q;
    assign bus.m1_rvalid  = m1_rvalid_q;
    assign bus.m1_rdata   = m1_rdata_q;
    assign bus.m1_err     = m1_err_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.mem_funct3 = mem_funct3_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire
